// File: rtl/addsub_pkg.sv
// Shared types and constants for the nibble-serial add/sub controller.
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the nibble counter; never below one bit so the counter stays legal.
  function automatic int cnt_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// 4-bit combinational add slice: {cout, sum} = a + b + cin.
// Operand inversion and carry chaining belong to the controller.
module addsub_slice
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o
);

  logic [NIBBLE_W:0] full_sum;

  // Plain ripple sum; the extra top bit is the carry-out.
  always_comb begin
    full_sum = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, cin_i};
    sum_o    = full_sum[NIBBLE_W-1:0];
    cout_o   = full_sum[NIBBLE_W];
  end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial add/subtract controller: round-robin arbitration between two
// requesters, one nibble per cycle through a shared 4-bit slice, result held
// on a valid/ready response channel.
//
// state | meaning
// IDLE  | waiting for a request; ready is offered to the granted requester
// BUSY  | one nibble per cycle through the slice, carry chained in carry_q
// DONE  | response presented, held until rsp_ready
module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_ovf
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = cnt_width(NIB);
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic                last_grant_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic                carry_q;
  logic                id_q;
  logic [WIDTH-1:0]    result_q;
  logic                cout_q;
  logic                ovf_q;

  logic                grant_d;
  logic                accept_d;
  logic [WIDTH-1:0]    a_sel_d;
  logic [WIDTH-1:0]    b_sel_d;
  logic                sub_sel_d;

  logic [NIBBLE_W-1:0] a_nib_d;
  logic [NIBBLE_W-1:0] b_nib_d;
  logic [NIBBLE_W-1:0] sum_nib_d;
  logic                cout_nib_d;
  logic [WIDTH-1:0]    result_d;
  logic                ovf_d;

  // Round-robin grant: a lone valid wins, a tie goes to whoever was not served last.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_d = ~last_grant_q;
    end else begin
      grant_d = req1_valid;
    end
  end

  assign req0_ready = (state_q == IDLE) && rst_n && req0_valid && !grant_d;
  assign req1_ready = (state_q == IDLE) && rst_n && req1_valid &&  grant_d;
  assign accept_d   = req0_ready || req1_ready;

  // Operand capture mux for the granted requester.
  always_comb begin
    a_sel_d   = grant_d ? req1_a   : req0_a;
    b_sel_d   = grant_d ? req1_b   : req0_b;
    sub_sel_d = grant_d ? req1_sub : req0_sub;
  end

  // Select the current nibble of each operand by the nibble counter.
  always_comb begin
    a_nib_d = '0;
    b_nib_d = '0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CW'(i)) begin
        a_nib_d = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib_d = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  addsub_slice u_slice (
    .a_i    (a_nib_d),
    .b_i    (b_nib_d),
    .cin_i  (carry_q),
    .sum_o  (sum_nib_d),
    .cout_o (cout_nib_d)
  );

  // Merge the fresh sum nibble into the result and derive signed overflow.
  // On the last step sum_nib_d[MSB] is the result MSB.
  always_comb begin
    result_d = result_q;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CW'(i)) begin
        result_d[i*NIBBLE_W +: NIBBLE_W] = sum_nib_d;
      end
    end
    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nib_d[NIBBLE_W-1] != a_q[WIDTH-1]);
  end

  // Sequencing FSM with all datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      carry_q      <= 1'b0;
      id_q         <= 1'b0;
      result_q     <= '0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            a_q          <= a_sel_d;
            b_q          <= b_sel_d ^ {WIDTH{sub_sel_d}};
            carry_q      <= sub_sel_d;
            id_q         <= grant_d;
            last_grant_q <= grant_d;
            cnt_q        <= '0;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          result_q <= result_d;
          carry_q  <= cout_nib_d;
          if (cnt_q == CNT_LAST) begin
            cout_q  <= cout_nib_d;
            ovf_q   <= ovf_d;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = (state_q == DONE);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_cout   = cout_q;
  assign rsp_ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Bench for addsub_seq_ctrl (WIDTH = 16): directed and random operations
// against a plain-arithmetic reference, arbitration, backpressure and reset.
module tb_addsub_seq_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_sub, req1_sub;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
  logic [W-1:0] rsp_result;

  int n_cmp = 0;
  int n_err = 0;

  addsub_seq_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic, carry as "no unsigned wrap / no borrow",
  // overflow as "signed true result out of 16-bit range".
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                 output logic [W-1:0] r, output logic c, output logic o);
    int sa, sb, t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    t  = sub ? (sa - sb) : (sa + sb);
    o  = (t > 32767) || (t < -32768);
    r  = sub ? (a - b) : (a + b);
    c  = sub ? (a >= b) : ((int'(a) + int'(b)) > 65535);
  endfunction

  // Drives one request and collects its response; no checking here.
  task automatic issue_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          output logic ok, output int lat, output logic [W-1:0] res,
                          output logic cout, output logic ovf, output logic rid, output logic valid_after);
    ok = 1'b0; lat = 0; res = '0; cout = 1'b0; ovf = 1'b0; rid = 1'b0; valid_after = 1'b1;
    @(negedge clk);
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if ((id == 0) ? req0_ready : req1_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      while (lat < 20 && !rsp_valid) begin
        @(posedge clk);
        #1;
        lat++;
      end
      if (rsp_valid) begin
        res = rsp_result; cout = rsp_cout; ovf = rsp_ovf; rid = rsp_id;
        @(posedge clk);
        #1;
        valid_after = rsp_valid;
      end else begin
        ok = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 16'h1111; req0_b = 16'h2222; req0_sub = 1'b0;
    req1_a = 16'h3333; req1_b = 16'h4444; req1_sub = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_cout, rsp_ovf} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got v/id/c/o=%b required 0000", {rsp_valid, rsp_id, rsp_cout, rsp_ovf});
    end
    n_cmp++;
    if (rsp_result !== 16'h0000) begin
      n_err++; $display("FAIL reset_result: got %h required 0000", rsp_result);
    end
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } vec_t;

  task automatic test_directed();
    vec_t tbl [6];
    logic ok, cout, ovf, rid, va;
    int lat;
    logic [W-1:0] res;
    tbl[0] = '{1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      issue_op(int'(tbl[k].id), tbl[k].a, tbl[k].b, tbl[k].sub, ok, lat, res, cout, ovf, rid, va);
      n_cmp++;
      if (ok !== 1'b1) begin
        n_err++; $display("FAIL dir%0d_handshake: got ok=%b required 1", k, ok);
      end
      n_cmp++;
      if (lat !== 4) begin
        n_err++; $display("FAIL dir%0d_latency: got %0d required 4", k, lat);
      end
      n_cmp++;
      if ({rid, res, cout, ovf} !== {tbl[k].id, tbl[k].r, tbl[k].c, tbl[k].o}) begin
        n_err++; $display("FAIL dir%0d_rsp: got id=%b res=%h c=%b o=%b required id=%b res=%h c=%b o=%b",
                          k, rid, res, cout, ovf, tbl[k].id, tbl[k].r, tbl[k].c, tbl[k].o);
      end
      n_cmp++;
      if (va !== 1'b0) begin
        n_err++; $display("FAIL dir%0d_release: got rsp_valid=%b required 0", k, va);
      end
    end
  endtask

  task automatic test_random();
    logic ok, cout, ovf, rid, va, sub, ec, eo;
    logic [W-1:0] a, b, res, er;
    logic [W-1:0] edge_vals [6];
    int lat, id;
    edge_vals[0] = 16'h0000; edge_vals[1] = 16'hFFFF; edge_vals[2] = 16'h7FFF;
    edge_vals[3] = 16'h8000; edge_vals[4] = 16'h0001; edge_vals[5] = 16'h000F;
    for (int k = 0; k < 40; k++) begin
      id  = int'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : W'($urandom);
      ref_op(a, b, sub, er, ec, eo);
      issue_op(id, a, b, sub, ok, lat, res, cout, ovf, rid, va);
      n_cmp++;
      if (ok !== 1'b1 || lat !== 4) begin
        n_err++; $display("FAIL rnd%0d_timing: got ok=%b lat=%0d required ok=1 lat=4", k, ok, lat);
      end
      n_cmp++;
      if ({rid, res, cout, ovf} !== {1'(id), er, ec, eo}) begin
        n_err++; $display("FAIL rnd%0d_rsp: a=%h b=%h sub=%b got id=%b res=%h c=%b o=%b required id=%0d res=%h c=%b o=%b",
                          k, a, b, sub, rid, res, cout, ovf, id, er, ec, eo);
      end
    end
  endtask

  task automatic test_arbitration();
    int grants [$];
    int cycs [$];
    rsp_ready = 1'b1;
    req0_a = 16'h0102; req0_b = 16'h0304; req0_sub = 1'b0;
    req1_a = 16'h0506; req1_b = 16'h0101; req1_sub = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      n_cmp++;
      if (req0_ready && req1_ready) begin
        n_err++; $display("FAIL arb_both_ready: cycle %0d got 11 required at most one", cyc);
      end
      if (req0_ready) begin grants.push_back(0); cycs.push_back(cyc); end
      if (req1_ready) begin grants.push_back(1); cycs.push_back(cyc); end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++;
    if (grants.size() < 4) begin
      n_err++; $display("FAIL arb_count: got %0d grants required >= 4", grants.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (grants[k] !== (k % 2)) begin
          n_err++; $display("FAIL arb_order%0d: got %0d required %0d", k, grants[k], k % 2);
        end
        if (k > 0) begin
          n_cmp++;
          if (cycs[k] - cycs[k-1] !== 6) begin
            n_err++; $display("FAIL arb_spacing%0d: got %0d required 6", k, cycs[k] - cycs[k-1]);
          end
        end
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic ok, ec, eo, c0, o0, id0;
    logic [W-1:0] a, b, er, r0;
    int n;
    a = W'($urandom); b = W'($urandom);
    ref_op(a, b, 1'b1, er, ec, eo);
    rsp_ready = 1'b0;
    ok = 1'b0;
    @(negedge clk);
    req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (req1_ready) ok = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL bp_accept: got no ready required ready within 20 cycles");
    end
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    n = 0;
    while (n < 20 && !rsp_valid) begin
      @(posedge clk);
      #1;
      n++;
    end
    r0 = rsp_result; c0 = rsp_cout; o0 = rsp_ovf; id0 = rsp_id;
    n_cmp++;
    if ({rsp_valid, id0, r0, c0, o0} !== {1'b1, 1'b1, er, ec, eo}) begin
      n_err++; $display("FAIL bp_rsp: got v=%b id=%b res=%h c=%b o=%b required v=1 id=1 res=%h c=%b o=%b",
                        rsp_valid, id0, r0, c0, o0, er, ec, eo);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_ovf} !== {1'b1, id0, r0, c0, o0}) begin
        n_err++; $display("FAIL bp_hold%0d: got v=%b res=%h required v=1 res=%h", k, rsp_valid, rsp_result, r0);
      end
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        n_err++; $display("FAIL bp_ready%0d: got %b required 00", k, {req0_ready, req1_ready});
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release: got rsp_valid=%b required 0", rsp_valid);
    end
    @(negedge clk);
    req1_valid = 1'b1;
    #1;
    n_cmp++;
    if (req1_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_idle: got req1_ready=%b required 1", req1_ready);
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ec, eo;
    logic [W-1:0] a, b, er;
    int n;
    rsp_ready = 1'b1;
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 16'h4321; req1_b = 16'h1111; req1_sub = 1'b0;
    n = 0;
    #1;
    while (n < 20 && !req1_ready) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
      n_err++; $display("FAIL rstmid_state: got v/r0/r1=%b required 000", {rsp_valid, req0_ready, req1_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL rstmid_dropped%0d: got rsp_valid=%b required 0", k, rsp_valid);
      end
    end
    a = W'($urandom); b = W'($urandom);
    ref_op(a, b, 1'b1, er, ec, eo);
    @(negedge clk);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = 1'b1;
    req1_valid = 1'b1; req1_a = 16'hAAAA; req1_b = 16'h5555; req1_sub = 1'b0;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL rstmid_tie: got r0/r1=%b required 10", {req0_ready, req1_ready});
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 0;
    while (n < 20 && !rsp_valid) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if ({n, rsp_id, rsp_result, rsp_cout, rsp_ovf} !== {32'd4, 1'b0, er, ec, eo}) begin
      n_err++; $display("FAIL rstmid_op: got lat=%0d id=%b res=%h c=%b o=%b required lat=4 id=0 res=%h c=%b o=%b",
                        n, rsp_id, rsp_result, rsp_cout, rsp_ovf, er, ec, eo);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
